// File: rtl/acc_muldiv_seq_pkg.sv
// acc_muldiv_seq_pkg: accumulator select encodings, data/ALU codes and sequencer states
package acc_muldiv_seq_pkg;
  typedef enum logic [1:0] {
    SEL_IDLE        = 2'b00,
    SEL_SHIFT_RIGHT = 2'b01,
    SEL_SHIFT_LEFT  = 2'b10,
    SEL_LOAD        = 2'b11
  } sel_e;
  localparam logic DATA_ALU = 1'b0;
  localparam logic DATA_BUS = 1'b1;
  localparam logic ALU_ADD  = 1'b0;
  localparam logic ALU_SUB  = 1'b1;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MUL_ADD,
    S_MUL_SHIFT,
    S_DIV_SHIFT,
    S_DIV_SUB,
    S_DIV_FINAL,
    S_DONE
  } state_e;
endpackage

// File: rtl/acc_muldiv_seq.sv
// acc_muldiv_seq: drives accumulator selects for shift-add multiply and restoring divide
module acc_muldiv_seq
  import acc_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       start,
  input  logic       op,
  input  logic       b_zero,
  input  logic       acc_low_lsb,
  input  logic       alu_carry,
  output logic       alu_sub,
  output logic [1:0] acc_high_select,
  output logic [1:0] acc_low_select,
  output logic       acc_in_select,
  output logic       fill_value,
  output logic       acc_high_reset_p,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam int CW = $clog2(WIDTH);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic op_q, op_d, err_q, err_d, carry_q, carry_d, q_q, q_d;
  logic last;
  assign last = cnt_q == CW'(WIDTH - 1);
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
      carry_q <= 1'b0;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      err_q   <= err_d;
      carry_q <= carry_d;
      q_q     <= q_d;
    end
  end
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    op_d             = op_q;
    err_d            = err_q;
    carry_d          = carry_q;
    q_d              = q_q;
    alu_sub          = ALU_ADD;
    acc_high_select  = SEL_IDLE;
    acc_low_select   = SEL_IDLE;
    fill_value       = 1'b0;
    acc_high_reset_p = 1'b0;
    done             = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        op_d    = op;
        err_d   = op & b_zero;
        state_d = (op & b_zero) ? S_DONE : S_CLEAR;
      end
      S_CLEAR: begin
        acc_high_reset_p = 1'b1;
        cnt_d            = '0;
        state_d          = op_q ? S_DIV_SHIFT : S_MUL_ADD;
      end
      S_MUL_ADD: begin
        acc_high_select = acc_low_lsb ? SEL_LOAD : SEL_IDLE;
        carry_d         = acc_low_lsb & alu_carry;
        state_d         = S_MUL_SHIFT;
      end
      S_MUL_SHIFT: begin
        acc_high_select = SEL_SHIFT_RIGHT;
        acc_low_select  = SEL_SHIFT_RIGHT;
        fill_value      = carry_q;
        cnt_d           = cnt_q + 1'b1;
        state_d         = last ? S_DONE : S_MUL_ADD;
      end
      // the first shift has no quotient bit yet, so q_q from a prior run must not leak in
      S_DIV_SHIFT: begin
        acc_high_select = SEL_SHIFT_LEFT;
        acc_low_select  = SEL_SHIFT_LEFT;
        fill_value      = (cnt_q != '0) & q_q;
        state_d         = S_DIV_SUB;
      end
      S_DIV_SUB: begin
        alu_sub         = ALU_SUB;
        acc_high_select = alu_carry ? SEL_IDLE : SEL_LOAD;
        q_d             = ~alu_carry;
        cnt_d           = cnt_q + 1'b1;
        state_d         = last ? S_DIV_FINAL : S_DIV_SHIFT;
      end
      S_DIV_FINAL: begin
        acc_low_select = SEL_SHIFT_LEFT;
        fill_value     = q_q;
        state_d        = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign err           = done & err_q;
  assign acc_in_select = DATA_ALU;
endmodule
